sync_req_arbiter: RTL and testbench
===================================

# sync_req_arbiter

Round-robin arbiter that shares one downstream resource among N_REQ requesters whose request lines are asynchronous to `clk`. Each request line passes through its own SYNC_STAGES-deep flip-flop synchronizer. A rising edge on the synchronized line latches a pending request. The arbiter then grants the resource to one pending requester at a time, using a valid/ready grant handshake followed by a done handshake. It sits between off-domain request sources (buttons, external strobes) and a shared single-user datapath.

## Interface
- N_REQ, 4, number of requesters; 2..16.
- SYNC_STAGES, 2, synchronizer depth per request line; minimum 2.
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT_DONE; used only with ARB_TIMEOUT_EN.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_async  in  N_REQ  asynchronous request lines; one rising edge is one request.
- grant_valid  out  1  a grant is offered on grant_id.
- grant_id  out  $clog2(N_REQ)  index of the granted requester; valid while grant_valid=1.
- grant_ready  in  1  resource accepts the offered grant.
- done  in  1  resource has finished serving the accepted grant.
- busy  out  1  high in GRANT and WAIT_DONE.
- overrun  out  1  one-cycle pulse when a new edge arrives for a requester whose pending bit is already set.
- timeout  out  1  one-cycle pulse when the watchdog aborts; tied 0 without ARB_TIMEOUT_EN.

## Operation
- Synchronizer: per requester, a SYNC_STAGES-deep shift chain. It is followed by one previous-value register used for edge detection; edge = sync & ~prev.
- Pending bits: one per requester.
  - Set on edge.
  - Cleared for grant_id on grant acceptance (grant_valid & grant_ready).
  - If set and clear hit the same bit in the same cycle, set wins, so the request is retained for a later service.
- overrun pulses when edge[i] occurs while pending[i]=1 and pending[i] is not being cleared that cycle. The request is coalesced.
- Round-robin pointer ptr, range 0..N_REQ-1.
  - Selection is the first pending index found scanning ptr, ptr+1, … modulo N_REQ.
  - On acceptance, ptr ← (grant_id+1) mod N_REQ.
- FSM states:
  - IDLE: if any pending bit is set, register the selected id into grant_id and go to GRANT. Otherwise stay in IDLE.
  - GRANT: grant_valid=1 and grant_id is held stable. On grant_ready go to WAIT_DONE. done is ignored in this state.
  - WAIT_DONE: on done, go to IDLE. grant_ready is ignored in this state.
- The FSM always passes through one IDLE cycle between services.
- Reset values: every synchronizer stage, prev, pending, and ptr are 0; state is IDLE; grant_valid, grant_id, busy, overrun and timeout are all 0.
- Reset asserted mid-operation discards all pending requests and any service in progress. No completion is reported.
- After reset deasserts, a req_async line that is already high counts as one rising edge, because prev resets to 0.

## Timing
- Let k be the clk edge that first samples req_async[i]=1. Then:
  - sync[i]=1 after edge k+SYNC_STAGES-1.
  - pending[i]=1 after edge k+SYNC_STAGES.
  - grant_valid=1 after edge k+SYNC_STAGES+1, provided the FSM is in IDLE.
- Acceptance: at the edge where grant_valid & grant_ready, the FSM enters WAIT_DONE and grant_valid drops in the same cycle. busy stays 1.
- done sampled high at edge d: state=IDLE after d. The earliest next grant_valid follows edge d+1.
- The minimum service period is 3 cycles: IDLE → GRANT → WAIT_DONE.
- A request pulse on req_async must be high for at least 2 clk periods to be guaranteed capture. Shorter pulses may be missed.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8–16-bit counter (width from TIMEOUT_CYCLES) clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES with done still low, timeout pulses for 1 cycle and the FSM goes to IDLE.
  - done and the timeout in the same cycle is treated as normal completion; no timeout pulse.
- ARB_TIMEOUT_EN not defined:
  - No counter is built and timeout is constant 0.
  - WAIT_DONE waits indefinitely for done.

## Test plan
- Reset check: assert reset asynchronously between edges → all outputs 0 at once. Release and hold req_async=0 for 10 cycles → grant_valid stays 0.
- Single request latency: N_REQ=4, SYNC_STAGES=2, req_async[2] high from edge k; grant_ready and done tied high → grant_valid=1 with grant_id=2 after edge k+3, WAIT_DONE after k+4, IDLE after k+5.
- Round-robin fairness: edges on requesters 0, 1 and 3 at the same time; grant_ready=1 and done one cycle after acceptance → grant order 0, 1, 3. Then a new edge on 0 with 3 also re-pending → order 3, 0, because ptr=0 after serving 3.
- Handshake stall: grant_ready held low for 20 cycles → grant_valid=1 and grant_id stable throughout; pulses on done are ignored; busy=1.
- Overrun and set-wins: two edges on requester 1 before it is granted → overrun pulses once and only one service is given. An edge on requester 1 in the acceptance cycle → a second service for 1 follows.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): accept a grant and hold done=0 → timeout pulses 8 cycles after entry to WAIT_DONE, then state=IDLE and the next pending requester is granted. Without the macro, the FSM stays in WAIT_DONE and timeout stays 0.

Source files
------------

// File: rtl/sync_req_arbiter.sv
// sync_req_arbiter
//   Round-robin arbiter sharing one downstream resource among N_REQ requesters
//   whose request lines are asynchronous to clk. Each line is synchronized,
//   rising edges latch pending requests, and one pending requester at a time
//   is offered a grant (valid/ready), then held until the resource reports done.
//
// Parameters
//   N_REQ          number of requesters (2..16)
//   SYNC_STAGES    synchronizer depth per request line (>= 2)
//   TIMEOUT_CYCLES WAIT_DONE watchdog limit, only used with ARB_TIMEOUT_EN
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high
//   req_async    in   [N_REQ]  asynchronous request lines, one rising edge = one request
//   grant_valid  out  grant offered on grant_id
//   grant_id     out  [$clog2(N_REQ)] index of the granted requester
//   grant_ready  in   resource accepts the offered grant
//   done         in   resource finished serving the accepted grant
//   busy         out  high in GRANT and WAIT_DONE
//   overrun      out  one-cycle pulse: new edge for an already-pending requester
//   timeout      out  one-cycle pulse: watchdog abort (0 unless ARB_TIMEOUT_EN)
//
// Build option
//   ARB_TIMEOUT_EN  when defined, a watchdog aborts WAIT_DONE after
//                   TIMEOUT_CYCLES cycles without done.
//
// States
//   IDLE      | no service in progress; picks the next pending requester
//   GRANT     | grant_valid offered, waiting for grant_ready
//   WAIT_DONE | grant accepted, waiting for done (or watchdog)

module sync_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_async,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  input  logic                     grant_ready,
  input  logic                     done,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int IDX_W = ID_W + 1;

  generate
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
      $error("sync_req_arbiter: N_REQ must be 2..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_req_arbiter: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("sync_req_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_REQ-1:0] sync_q [SYNC_STAGES];
  logic [N_REQ-1:0] sync;
  logic [N_REQ-1:0] prev;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] clr_mask;
  logic [N_REQ-1:0] pending_nxt;
  logic             overrun_nxt;
  logic             accept;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel_id;
  logic             sel_found;
  logic [IDX_W-1:0] scan_idx;
  logic [ID_W-1:0]  grant_id_nxt;
  logic             timeout_nxt;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev <= '0;
    end else begin
      sync_q[0] <= req_async;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev <= sync;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  // prev resets to 0, so a line already high when reset releases counts as one edge.
  assign rise = sync & ~prev;

  // ---------------------------------------------------------------------------
  // Pending requests
  // ---------------------------------------------------------------------------
  assign grant_valid = (state == GRANT);
  assign busy        = (state == GRANT) || (state == WAIT_DONE);
  assign accept      = grant_valid & grant_ready;

  always_comb begin
    clr_mask = '0;
    if (accept) begin
      clr_mask[grant_id] = 1'b1;
    end
  end

  // Set wins over clear: an edge arriving in the acceptance cycle stays pending
  // for a later service instead of being lost.
  assign pending_nxt = (pending & ~clr_mask) | rise;
  assign overrun_nxt = |(rise & pending & ~clr_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection: first pending index scanning ptr, ptr+1, ... mod N_REQ
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      // ptr + off never exceeds 2*N_REQ-2, which fits in IDX_W bits.
      scan_idx = {1'b0, ptr} + IDX_W'(off);
      if (scan_idx >= IDX_W'(N_REQ)) begin
        scan_idx = scan_idx - IDX_W'(N_REQ);
      end
      if (!sel_found && pending[scan_idx[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      if (grant_id == ID_W'(N_REQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_id + ID_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // WAIT_DONE watchdog
  // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expired;

  // Counter holds the number of completed WAIT_DONE cycles; the abort edge is
  // the TIMEOUT_CYCLES-th edge after entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (state == WAIT_DONE) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign wd_expired = (state == WAIT_DONE) && (wd_cnt == CNT_LAST);
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_id_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_id_nxt = grant_id;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_id_nxt = sel_id;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          state_nxt = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_expired) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_nxt;
    end
  end
`else
  // No watchdog: the abort request never fires, WAIT_DONE waits for done.
  assign timeout = timeout_nxt;
`endif

endmodule

// File: tb/tb_sync_req_arbiter.sv
module tb_sync_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_async = '0;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       grant_ready = 1'b0;
  logic       done = 1'b0;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  sync_req_arbiter #(
    .N_REQ          (N),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_async   (req_async),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_ready (grant_ready),
    .done        (done),
    .busy        (busy),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       dn;
    logic       gv;
    logic [1:0] id;
    logic       bsy;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [3:0] q, logic rd, logic dn,
                              logic gv, logic [1:0] id, logic bs, logic ov);
    vec_t v;
    v.rst = r; v.req = q; v.rdy = rd; v.dn = dn;
    v.gv = gv; v.id = id; v.bsy = bs; v.ovr = ov;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset pulses between edges and releases before the next edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
  endtask

  task automatic wait_gv(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (grant_valid) ok = 1'b1;
    end
  endtask

  bit ok;

  initial begin
    // Single request latency on requester 2, ready/done tied high.
    add(1, 4'b0100, 1, 1, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 1, 2, 1, 0);
    add(0, 4'b0100, 1, 1, 0, 0, 1, 0);
    add(0, 4'b0100, 1, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
    // Round robin: 0,1,3 together, then 0 and 3 re-pend in 3's acceptance cycle.
    add(1, 4'b1011, 1, 1, 0, 0, 0, 0);
    add(0, 4'b1011, 1, 1, 0, 0, 0, 0);
    add(0, 4'b1011, 1, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 1, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 1, 0);
    add(0, 4'b1001, 1, 1, 0, 0, 0, 0);
    add(0, 4'b1001, 1, 1, 1, 3, 1, 0);
    add(0, 4'b1001, 1, 1, 0, 0, 1, 0);
    add(0, 4'b1001, 1, 1, 0, 0, 0, 0);
    add(0, 4'b1001, 1, 1, 1, 0, 1, 0);
    add(0, 4'b1001, 1, 1, 0, 0, 1, 0);
    add(0, 4'b1001, 1, 1, 0, 0, 0, 0);
    add(0, 4'b1001, 1, 1, 1, 3, 1, 0);
    add(0, 4'b1001, 1, 1, 0, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
    // Overrun: second edge on 1 while it waits for acceptance, one service only.
    add(1, 4'b0010, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 1, 1, 1, 0);
    add(0, 4'b0000, 0, 0, 1, 1, 1, 0);
    add(0, 4'b0010, 0, 0, 1, 1, 1, 0);
    add(0, 4'b0010, 0, 0, 1, 1, 1, 0);
    add(0, 4'b0010, 0, 0, 1, 1, 1, 1);
    add(0, 4'b0010, 0, 0, 1, 1, 1, 0);
    add(0, 4'b0010, 1, 0, 0, 0, 1, 0);
    add(0, 4'b0010, 0, 1, 0, 0, 0, 0);
    add(0, 4'b0010, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_gv", grant_valid, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_to", timeout, 0);
    #4 reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      req_async   = tbl[i].req;
      grant_ready = tbl[i].rdy;
      done        = tbl[i].dn;
      tick();
      chk($sformatf("row%0d_gv", i), grant_valid, tbl[i].gv);
      if (tbl[i].gv) chk($sformatf("row%0d_id", i), grant_id, tbl[i].id);
      chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("row%0d_ovr", i), overrun, tbl[i].ovr);
      chk($sformatf("row%0d_to", i), timeout, 0);
    end

    // Handshake stall with done pulses, then watchdog behaviour.
    do_reset();
    req_async = 4'b0100; grant_ready = 1'b0; done = 1'b0;
    wait_gv(10, ok);
    chk("stall_found", ok, 1);
    chk("stall_id0", grant_id, 2);
    req_async = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      done = i[0];
      tick();
      chk($sformatf("stall%0d_gv", i), grant_valid, 1);
      chk($sformatf("stall%0d_id", i), grant_id, 2);
      chk($sformatf("stall%0d_busy", i), busy, 1);
    end
    done = 1'b0; grant_ready = 1'b1;
    tick();
    chk("accept_gv", grant_valid, 0);
    chk("accept_busy", busy, 1);
    grant_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int n = 1; n <= TO; n++) begin
      tick();
      if (n < TO) begin
        chk($sformatf("wd%0d_to", n), timeout, 0);
        chk($sformatf("wd%0d_busy", n), busy, 1);
      end else begin
        chk("wd_to_pulse", timeout, 1);
        chk("wd_idle", busy, 0);
      end
    end
    tick();
    chk("wd_to_clear", timeout, 0);
    chk("wd_next_gv", grant_valid, 1);
    chk("wd_next_id", grant_id, 0);
`else
    for (int n = 0; n < 30; n++) begin
      tick();
      chk($sformatf("nowd%0d_busy", n), busy, 1);
      chk($sformatf("nowd%0d_gv", n), grant_valid, 0);
      chk($sformatf("nowd%0d_to", n), timeout, 0);
    end
    done = 1'b1;
    tick();
    chk("nowd_done_idle", busy, 0);
    done = 1'b0;
    tick();
    chk("nowd_next_gv", grant_valid, 1);
    chk("nowd_next_id", grant_id, 0);
`endif

    // Asynchronous reset mid-grant discards everything.
    req_async = 4'b0000;
    #3 reset = 1'b1;
    #1;
    chk("areset_gv", grant_valid, 0);
    chk("areset_id", grant_id, 0);
    chk("areset_busy", busy, 0);
    chk("areset_ovr", overrun, 0);
    chk("areset_to", timeout, 0);
    #2 reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk($sformatf("post_rst%0d_gv", n), grant_valid, 0);
      chk($sformatf("post_rst%0d_busy", n), busy, 0);
    end

    // A line held high through reset counts as one request.
    req_async = 4'b1000;
    do_reset();
    wait_gv(10, ok);
    chk("held_found", ok, 1);
    chk("held_id", grant_id, 3);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0; done = 1'b1;
    tick();
    done = 1'b0;
    tick(); tick();
    chk("held_once_gv", grant_valid, 0);

    // Set wins: edge on 1 in its own acceptance cycle gives a second service.
    do_reset();
    req_async = 4'b0010; grant_ready = 1'b0; done = 1'b0;
    wait_gv(10, ok);
    chk("sw_found", ok, 1);
    chk("sw_id", grant_id, 1);
    req_async = 4'b0000;
    tick(); tick(); tick();
    req_async = 4'b0010;
    tick(); tick();
    grant_ready = 1'b1;
    tick();
    chk("sw_acc_gv", grant_valid, 0);
    chk("sw_acc_busy", busy, 1);
    chk("sw_acc_ovr", overrun, 0);
    grant_ready = 1'b0; done = 1'b1;
    tick();
    chk("sw_idle", busy, 0);
    done = 1'b0;
    tick();
    chk("sw_second_gv", grant_valid, 1);
    chk("sw_second_id", grant_id, 1);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0; done = 1'b1;
    tick();
    done = 1'b0;
    tick(); tick();
    chk("sw_no_third_gv", grant_valid, 0);
    chk("sw_no_third_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
